// File: rtl/clusterv_sram_pkg.sv
// Shared definitions for the tile's bus-to-SRAM bridges.
// Contents:
//   bridge_state_e - access sequencer states (idle, read wait, response dead cycle)
//   byte_lanes()   - number of byte lanes for a given data width
//   window_mask()  - byte-offset mask covering a 2**sram_aw word SRAM window
package clusterv_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } bridge_state_e;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // One word is four bytes, so the window spans 4*2**sram_aw bytes.
  function automatic logic [63:0] window_mask(input int sram_aw);
    return (64'd4 << sram_aw) - 64'd1;
  endfunction

endpackage

// File: rtl/clusterv_tile_wb_sram_bridge.sv
// Wishbone B4 classic slave in front of the tile's single-port byte-enable SRAM.
// One access is in flight at a time; every bus and SRAM output is a register.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   wb_adr_i..wb_sel_i    - Wishbone request (byte address, write data, cyc/stb/we/sel)
//   wb_dat_r_o            - registered read data, held until the next read capture
//   wb_ack_o / wb_err_o   - one-cycle acknowledge / out-of-window error
//   sram_addr..write_data - SRAM request, enables are single-cycle pulses
//   sram_read_data        - SRAM read data, valid RD_LAT cycles after read_en is sampled
module clusterv_tile_wb_sram_bridge
  import clusterv_sram_pkg::*;
#(
  parameter int                  WB_ADR_W  = 32,
  parameter int                  DATA_W    = 32,
  parameter int                  SRAM_AW   = 8,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                  RD_LAT    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WB_ADR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_w_i,
  output logic [DATA_W-1:0]     wb_dat_r_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic                  sram_read_en,
  output logic                  sram_write_en,
  output logic [DATA_W/8-1:0]   sram_byte_en,
  output logic [DATA_W-1:0]     sram_write_data,
  input  logic [DATA_W-1:0]     sram_read_data
);

  localparam int                  NUM_LANES = byte_lanes(DATA_W);
  localparam logic [WB_ADR_W-1:0] WIN_MASK  = WB_ADR_W'(window_mask(SRAM_AW));
  localparam logic [1:0]          LAT_LOAD  = 2'(RD_LAT);

  bridge_state_e        state_r;
  logic [1:0]           cnt_r;
  logic                 req_s;
  logic                 hit_s;
  logic [SRAM_AW-1:0]   word_s;

  assign req_s  = wb_cyc_i & wb_stb_i;
  assign hit_s  = ((wb_adr_i & ~WIN_MASK) == BASE_ADDR);
  assign word_s = wb_adr_i[SRAM_AW+1:2];

  // Access sequencer: accepts a request in IDLE, pulses the SRAM, returns ack/err.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 2'd0;
      wb_dat_r_o      <= {DATA_W{1'b0}};
      wb_ack_o        <= 1'b0;
      wb_err_o        <= 1'b0;
      sram_addr       <= {SRAM_AW{1'b0}};
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_byte_en    <= {NUM_LANES{1'b0}};
      sram_write_data <= {DATA_W{1'b0}};
    end else begin
      // Pulses default low; only the accepting/completing edge raises them.
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            if (!hit_s) begin
              wb_err_o <= 1'b1;
              state_r  <= ST_RESP;
            end else if (wb_we_i) begin
              // A write with no byte selected is acknowledged but never reaches the macro.
              sram_write_en   <= (wb_sel_i != {NUM_LANES{1'b0}});
              sram_byte_en    <= wb_sel_i;
              sram_addr       <= word_s;
              sram_write_data <= wb_dat_w_i;
              wb_ack_o        <= 1'b1;
              state_r         <= ST_RESP;
            end else begin
              sram_read_en <= 1'b1;
              sram_byte_en <= {NUM_LANES{1'b0}};
              sram_addr    <= word_s;
              cnt_r        <= LAT_LOAD;
              state_r      <= ST_RD_WAIT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (!wb_cyc_i) begin
            // Master gave up: drop the pending read without responding.
            cnt_r   <= 2'd0;
            state_r <= ST_IDLE;
          end else if (cnt_r == 2'd0) begin
            wb_dat_r_o <= sram_read_data;
            wb_ack_o   <= 1'b1;
            state_r    <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_RESP: begin
          // Dead cycle so a strobe still held high is not taken twice.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
